// File: rtl/gray_pkg.sv
// Shared types and default geometry for the pipelined Gray/binary codec.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH = 32;
  localparam int unsigned GRAY_CHUNK = 8;

  typedef enum logic {
    GRAY_DECODE = 1'b0,
    GRAY_ENCODE = 1'b1
  } gray_mode_t;

endpackage

// File: rtl/gray_chunk_stage.sv
// Combinational Gray->binary resolution of one CHUNK-bit slice of the word.
module gray_chunk_stage
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH,
  parameter int unsigned CHUNK = GRAY_CHUNK,
  parameter int unsigned IDX   = 0
) (
  input  logic [WIDTH-1:0] word,
  input  logic             carry_in,
  output logic [WIDTH-1:0] resolved,
  output logic             carry_out
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LSB    = (STAGES - 1 - IDX) * CHUNK;

  logic [CHUNK-1:0] g_slice;
  logic [CHUNK-1:0] b_slice;

  assign g_slice = word[LSB +: CHUNK];

  // Each binary bit is the carry XOR every Gray bit at or above it in the slice.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign b_slice[i] = carry_in ^ (^g_slice[CHUNK-1:i]);
  end

  always_comb begin
    resolved             = word;
    resolved[LSB +: CHUNK] = b_slice;
  end

  assign carry_out = b_slice[0];

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray<->binary converter, one slice per stage, valid/ready on both sides.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH,
  parameter int unsigned CHUNK = GRAY_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_chunk_check
    $error("gray_codec_pipe: WIDTH must be a multiple of CHUNK");
  end

  logic [STAGES-1:0]            v_all;
  logic [STAGES-1:0]            m_all;
  logic [STAGES-1:0]            c_all;
  logic [STAGES-1:0][WIDTH-1:0] w_all;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_valid;
    gray_mode_t       src_mode;
    logic [WIDTH-1:0] src_word;
    logic             src_carry;
    logic [WIDTH-1:0] dec_word;
    logic             dec_carry;
    logic [WIDTH-1:0] nxt_word;
    logic             nxt_carry;
    logic             load;
    logic             v_q;
    gray_mode_t       m_q;
    logic [WIDTH-1:0] w_q;
    logic             c_q;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_mode  = gray_mode_t'(in_mode);
      assign src_word  = in_data;
      assign src_carry = 1'b0;
    end else begin : g_tail
      assign src_valid = v_all[k-1];
      assign src_mode  = gray_mode_t'(m_all[k-1]);
      assign src_word  = w_all[k-1];
      assign src_carry = c_all[k-1];
    end

    gray_chunk_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_chunk (
      .word      (src_word),
      .carry_in  (src_carry),
      .resolved  (dec_word),
      .carry_out (dec_carry)
    );

    // Encode is finished in stage 0; later stages only carry it along.
    always_comb begin
      nxt_word  = dec_word;
      nxt_carry = dec_carry;
      if (src_mode == GRAY_ENCODE) begin
        nxt_word  = (k == 0) ? (src_word ^ (src_word >> 1)) : src_word;
        nxt_carry = 1'b0;
      end
    end

    // Slot may load when it, or any slot downstream of it, is empty, or the sink takes.
    assign load = out_ready || !(&v_all[STAGES-1:k]);

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        m_q <= GRAY_DECODE;
        w_q <= '0;
        c_q <= 1'b0;
      end else if (load) begin
        v_q <= src_valid;
        if (src_valid) begin
          m_q <= src_mode;
          w_q <= nxt_word;
          c_q <= nxt_carry;
        end
      end
    end

    assign v_all[k] = v_q;
    assign m_all[k] = m_q;
    assign w_all[k] = w_q;
    assign c_all[k] = c_q;
  end

  // The last slot's carry has no consumer; the word already holds every resolved bit.
  logic unused_last_carry;
  assign unused_last_carry = c_all[STAGES-1];

  assign in_ready  = out_ready || !(&v_all);
  assign out_valid = v_all[STAGES-1];
  assign out_data  = w_all[STAGES-1];
  assign out_mode  = m_all[STAGES-1];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Self-checking bench: directed checks on 32/8 plus randomized traffic on 16/4, 32/32, 64/8.
module tb_gray_codec_pipe;

  localparam int NCFG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference conversion: binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [63:0] ref_conv(input logic [63:0] x, input int w, input logic m);
    logic [63:0] mask;
    logic [63:0] b;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    b = x & mask;
    if (m) return (b ^ (b >> 1)) & mask;
    for (int s = 1; s < w; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

  function automatic int cfg_w(input int i);
    case (i)
      0: return 32;
      1: return 16;
      2: return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_c(input int i);
    case (i)
      0: return 8;
      1: return 4;
      2: return 32;
      default: return 8;
    endcase
  endfunction

  logic        d_rst;
  logic        d_in_valid;
  logic        d_in_ready;
  logic [31:0] d_in_data;
  logic        d_in_mode;
  logic        d_out_valid;
  logic        d_out_ready;
  logic [31:0] d_out_data;
  logic        d_out_mode;

  for (genvar gi = 0; gi < NCFG; gi++) begin : cfg
    localparam int unsigned W = cfg_w(gi);
    localparam int unsigned C = cfg_c(gi);

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_mode;
    logic         done;

    logic [W-1:0] q_data[$];
    logic         q_mode[$];
    int           n_out      = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_mode;
    logic         was_rst    = 1'b0;

    gray_codec_pipe #(
      .WIDTH (W),
      .CHUNK (C)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mode  (out_mode)
    );

    // Scoreboard: expected results queued at input transfer, popped at output transfer.
    always @(negedge clk) begin
      logic [W-1:0] ed;
      logic         em;
      if (was_rst) begin
        chk($sformatf("cfg%0d rst out_valid", gi), 64'(out_valid), 64'd0);
        chk($sformatf("cfg%0d rst out_data", gi), 64'(out_data), 64'd0);
      end else if (prev_stall) begin
        chk($sformatf("cfg%0d hold valid", gi), 64'(out_valid), 64'd1);
        chk($sformatf("cfg%0d hold data", gi), 64'(out_data), 64'(prev_data));
        chk($sformatf("cfg%0d hold mode", gi), 64'(out_mode), 64'(prev_mode));
      end
      if (rst) begin
        q_data.delete();
        q_mode.delete();
        prev_stall = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (q_data.size() == 0) begin
            chk($sformatf("cfg%0d unexpected beat", gi), 64'd1, 64'd0);
          end else begin
            ed = q_data.pop_front();
            em = q_mode.pop_front();
            chk($sformatf("cfg%0d data", gi), 64'(out_data), 64'(ed));
            chk($sformatf("cfg%0d mode", gi), 64'(out_mode), 64'(em));
          end
          n_out++;
        end
        if (in_valid && in_ready) begin
          q_data.push_back(W'(ref_conv(64'(in_data), int'(W), in_mode)));
          q_mode.push_back(in_mode);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_mode  = out_mode;
      end
      was_rst = rst;
    end

    if (gi == 0) begin : dir
      assign rst         = d_rst;
      assign in_valid    = d_in_valid;
      assign in_data     = W'(d_in_data);
      assign in_mode     = d_in_mode;
      assign out_ready   = d_out_ready;
      assign d_in_ready  = in_ready;
      assign d_out_valid = out_valid;
      assign d_out_data  = 32'(out_data);
      assign d_out_mode  = out_mode;
      assign done        = 1'b1;
    end else begin : rnd
      initial begin
        done      = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
          in_valid  = ($urandom_range(3) != 0);
          in_mode   = 1'($urandom_range(1));
          in_data   = W'({$urandom, $urandom});
          out_ready = ($urandom_range(2) != 0) && ((c % 250) < 230);
          rst       = ($urandom_range(299) == 0);
          @(posedge clk);
          #1;
        end
        in_valid  = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk($sformatf("cfg%0d drained", gi), 64'(q_data.size()), 64'd0);
        done = 1'b1;
      end
    end
  end

  // Presents one beat into an empty pipe and checks it appears exactly four cycles later.
  task automatic lat_check(input logic [31:0] din, input logic m, input logic [31:0] exp);
    @(posedge clk);
    #1;
    d_in_valid = 1'b1;
    d_in_data  = din;
    d_in_mode  = m;
    d_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("latency valid c%0d", c), 64'(d_out_valid), (c == 4) ? 64'd1 : 64'd0);
      if (c == 4) begin
        chk("latency data", 64'(d_out_data), 64'(exp));
        chk("latency mode", 64'(d_out_mode), 64'(m));
      end
      @(posedge clk);
      #1;
      d_in_valid = 1'b0;
    end
  endtask

  initial begin
    int          got;
    logic [31:0] rd[2];
    logic        rm[2];
    int          w;
    int          acc;
    int          nxt;
    int          n0;
    int          guard;
    logic        ir;

    d_rst       = 1'b1;
    d_in_valid  = 1'b0;
    d_in_data   = '0;
    d_in_mode   = 1'b0;
    d_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 d_rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 64'(d_out_valid), 64'd0);
    chk("reset out_data", 64'(d_out_data), 64'd0);
    chk("reset out_mode", 64'(d_out_mode), 64'd0);
    chk("reset in_ready", 64'(d_in_ready), 64'd1);

    // MSB-only Gray word decodes to all ones.
    lat_check(32'h8000_0000, 1'b0, 32'hFFFF_FFFF);

    // Decode then encode back to back; order and mode must be preserved.
    @(posedge clk);
    #1;
    d_in_valid = 1'b1;
    d_in_mode  = 1'b0;
    d_in_data  = 32'h0000_0003;
    @(posedge clk);
    #1;
    d_in_mode  = 1'b1;
    d_in_data  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    d_in_mode  = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (d_out_valid && d_out_ready) begin
        if (got < 2) begin
          rd[got] = d_out_data;
          rm[got] = d_out_mode;
        end
        got++;
      end
    end
    chk("pair count", 64'(got), 64'd2);
    chk("decode 3", 64'(rd[0]), 64'h2);
    chk("decode 3 mode", 64'(rm[0]), 64'd0);
    chk("encode ones", 64'(rd[1]), 64'h8000_0000);
    chk("encode ones mode", 64'(rm[1]), 64'd1);

    // Back-to-back stream of Gray-coded counter values.
    d_out_ready = 1'b1;
    w = 0;
    fork
      begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) begin
          d_in_valid = 1'b1;
          d_in_data  = 32'(i ^ (i >> 1));
          @(posedge clk);
          #1;
        end
        d_in_valid = 1'b0;
      end
      begin
        while (!d_out_valid && w < 12) begin
          @(negedge clk);
          w++;
        end
        chk("stream start", 64'(w < 12), 64'd1);
        for (int k = 0; k < 1024; k++) begin
          if (k > 0) @(negedge clk);
          chk("stream valid", 64'(d_out_valid), 64'd1);
          chk("stream data", 64'(d_out_data), 64'(k));
        end
      end
    join
    repeat (6) @(negedge clk);

    // Backpressure from an empty pipe: four accepts, then a full stall with stable output.
    n0 = cfg[0].n_out;
    @(posedge clk);
    #1;
    d_out_ready = 1'b0;
    nxt = 100;
    acc = 0;
    ir  = 1'b0;
    d_in_valid = 1'b1;
    d_in_mode  = 1'b0;
    d_in_data  = 32'(nxt ^ (nxt >> 1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ir = d_in_ready;
      if (c >= 4) begin
        chk("stall valid", 64'(d_out_valid), 64'd1);
        chk("stall data", 64'(d_out_data), 64'd100);
      end
      @(posedge clk);
      #1;
      if (ir) begin
        acc++;
        nxt++;
        d_in_data = 32'(nxt ^ (nxt >> 1));
      end
    end
    chk("stall accepts", 64'(acc), 64'd4);
    chk("stall in_ready", 64'(ir), 64'd0);
    d_out_ready = 1'b1;
    guard = 0;
    while (acc < 12 && guard < 100) begin
      @(negedge clk);
      ir = d_in_ready;
      @(posedge clk);
      #1;
      if (ir) begin
        acc++;
        nxt++;
        d_in_data = 32'(nxt ^ (nxt >> 1));
      end
      guard++;
    end
    d_in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("stall beats out", 64'(cfg[0].n_out - n0), 64'd12);
    chk("stall queue empty", 64'(cfg[0].q_data.size()), 64'd0);

    // One-cycle reset with three beats in flight.
    @(posedge clk);
    #1;
    d_in_valid = 1'b1;
    d_in_mode  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_in_data = 32'(i + 7);
      @(posedge clk);
      #1;
    end
    d_in_valid = 1'b0;
    d_rst      = 1'b1;
    @(posedge clk);
    #1;
    d_rst = 1'b0;
    @(negedge clk);
    chk("flush out_valid", 64'(d_out_valid), 64'd0);
    lat_check(32'h0000_00FF, 1'b0, 32'h0000_00AA);

    guard = 0;
    while (!(cfg[1].done && cfg[2].done && cfg[3].done) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    chk("random configs done", 64'({cfg[3].done, cfg[2].done, cfg[1].done}), 64'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
